// File: rtl/demux1to3_32b_buf.sv
// Registered 1-to-3 distributor: one input word is steered by in_sel to one of
// three single-entry output buffers, each with its own valid/ready handshake.
module demux1to3_32b_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] deliver_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] data_q [3];
    logic [WIDTH-1:0] data_d [3];
    logic [2:0]       valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] deliver_q, deliver_d;

    logic [2:0]       ready_vec;
    logic [2:0]       take;
    logic [2:0]       load;
    logic             accept;
    logic             illegal;
    logic [1:0]       n_take;
    logic [CNT_W:0]   deliver_sum;

    assign ready_vec = {out2_ready, out1_ready, out0_ready};

    // in_ready looks only at the addressed channel, so a stall elsewhere never blocks
    always_comb begin
        case (in_sel)
            2'd0:    in_ready = !valid_q[0] || out0_ready;
            2'd1:    in_ready = !valid_q[1] || out1_ready;
            2'd2:    in_ready = !valid_q[2] || out2_ready;
            default: in_ready = 1'b1;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign illegal = accept && (in_sel == 2'b11);

    always_comb begin
        take    = valid_q & ready_vec;
        load    = 3'b000;
        valid_d = valid_q;
        for (int k = 0; k < 3; k++) begin
            data_d[k] = data_q[k];
            load[k]   = accept && (in_sel == 2'(k));
            // A load in the same edge as a drain refills the buffer without a bubble
            if (load[k]) begin
                data_d[k]  = in_data;
                valid_d[k] = 1'b1;
            end else if (take[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        n_take      = {1'b0, take[0]} + {1'b0, take[1]} + {1'b0, take[2]};
        deliver_sum = {1'b0, deliver_q} + (CNT_W + 1)'(n_take);
        deliver_d   = (deliver_sum > {1'b0, CNT_MAX}) ? CNT_MAX : deliver_sum[CNT_W-1:0];
        drop_d      = (illegal && (drop_q != CNT_MAX)) ? drop_q + CNT_W'(1) : drop_q;
        // A drop in the same cycle as err_clr keeps the flag set
        err_d       = illegal || (err_q && !err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= '0;
            end
            valid_q   <= '0;
            err_q     <= 1'b0;
            drop_q    <= '0;
            deliver_q <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q   <= valid_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            deliver_q <= deliver_d;
        end
    end

    assign out0_data     = data_q[0];
    assign out1_data     = data_q[1];
    assign out2_data     = data_q[2];
    assign out0_valid    = valid_q[0];
    assign out1_valid    = valid_q[1];
    assign out2_valid    = valid_q[2];
    assign err           = err_q;
    assign drop_count    = drop_q;
    assign deliver_count = deliver_q;

endmodule
